// File: rtl/serial_link_ddr_rx.sv
// Receive side of the FPGA-to-FPGA DDR nibble link: synchronizes the link inputs,
// reassembles 32-bit words LSB-nibble first and queues them in a valid/ready FIFO.
module serial_link_ddr_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic [3:0]  ddr_i,
    input  logic        ddr_rcv_clk_i,
    input  logic        link_valid_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic        fifo_empty_o,
    output logic        fifo_full_o,
    output logic        overflow_o,
    output logic        frame_err_o,
    input  logic        clear_i
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    logic [SYNC_STAGES-1:0] lclk_chain;
    logic [SYNC_STAGES-1:0] valid_chain;
    logic [3:0]             data_chain [SYNC_STAGES];
    logic                   lclk_q;

    logic                   lclk_sync;
    logic                   valid_sync;
    logic [3:0]             data_sync;
    logic                   link_event;

    state_t                 state_q, state_d;
    logic [2:0]             nib_cnt_q, nib_cnt_d;
    logic [27:0]            shift_q, shift_d;
    logic                   seen_idle_q;

    logic                   push;
    logic [31:0]            push_word;
    logic                   frame_err_set;

    logic [31:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic                   pop;
    logic                   push_ok;
    logic                   overflow_set;

    // The valid chain resets high so a frame still in flight at reset release
    // is never mistaken for an idle line.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            lclk_chain  <= '0;
            valid_chain <= '1;
            lclk_q      <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_chain[i] <= '0;
            end
        end else begin
            lclk_chain    <= {lclk_chain[SYNC_STAGES-2:0], ddr_rcv_clk_i};
            valid_chain   <= {valid_chain[SYNC_STAGES-2:0], link_valid_i};
            data_chain[0] <= ddr_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_chain[i] <= data_chain[i-1];
            end
            lclk_q <= lclk_sync;
        end
    end

    assign lclk_sync  = lclk_chain[SYNC_STAGES-1];
    assign valid_sync = valid_chain[SYNC_STAGES-1];
    assign data_sync  = data_chain[SYNC_STAGES-1];
    assign link_event = lclk_sync != lclk_q;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nib_cnt_q   <= '0;
            shift_q     <= '0;
            seen_idle_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            shift_q   <= shift_d;
            if (!valid_sync) begin
                seen_idle_q <= 1'b1;
            end
        end
    end

    // The eighth nibble is pushed straight from the synchronizer so the word
    // reaches the FIFO in the same cycle it completes.
    always_comb begin
        state_d       = state_q;
        nib_cnt_d     = nib_cnt_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        push_word     = {data_sync, shift_q};
        case (state_q)
            IDLE: begin
                if (link_event && valid_sync && seen_idle_q) begin
                    shift_d[3:0] = data_sync;
                    nib_cnt_d    = 3'd1;
                    state_d      = RECV;
                end
            end
            RECV: begin
                if (!valid_sync) begin
                    frame_err_set = 1'b1;
                    nib_cnt_d     = '0;
                    state_d       = IDLE;
                end else if (link_event) begin
                    if (nib_cnt_q == 3'd7) begin
                        push      = 1'b1;
                        nib_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        for (int i = 1; i < 7; i++) begin
                            if (nib_cnt_q == 3'(i)) begin
                                shift_d[4*i +: 4] = data_sync;
                            end
                        end
                        nib_cnt_d = nib_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                nib_cnt_d = '0;
            end
        endcase
    end

    assign fifo_empty_o = wr_ptr_q == rd_ptr_q;
    assign fifo_full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                          (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rvalid_o     = !fifo_empty_o;
    assign rdata_o      = fifo_empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

    assign pop          = rvalid_o && rready_i;
    assign push_ok      = push && (!fifo_full_o || pop);
    assign overflow_set = push && fifo_full_o && !pop;

    always_ff @(posedge clk_gen) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // A new error in the same cycle as clear_i must stay visible.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_o <= 1'b1;
            end else if (clear_i) begin
                overflow_o <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err_o <= 1'b1;
            end else if (clear_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_link_ddr_rx.sv
// Directed bench for serial_link_ddr_rx: a scoreboard queue holds the words the
// link should deliver and a negedge monitor checks every word the FIFO hands out.
module tb_serial_link_ddr_rx;

    logic        clk_gen = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ddr = 4'h0;
    logic        lclk = 1'b0;
    logic        link_valid = 1'b0;
    logic        rready = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fifo_empty;
    logic        fifo_full;
    logic        overflow;
    logic        frame_err;

    int          total = 0;
    int          bad = 0;
    int          rv_cnt = 0;
    int          rv_start;
    logic [31:0] exp_q [$];

    serial_link_ddr_rx dut (
        .clk_gen       (clk_gen),
        .rst_n         (rst_n),
        .ddr_i         (ddr),
        .ddr_rcv_clk_i (lclk),
        .link_valid_i  (link_valid),
        .rdata_o       (rdata),
        .rvalid_o      (rvalid),
        .rready_i      (rready),
        .fifo_empty_o  (fifo_empty),
        .fifo_full_o   (fifo_full),
        .overflow_o    (overflow),
        .frame_err_o   (frame_err),
        .clear_i       (clear)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_gen);
        #1;
    endtask

    // Every accepted word is compared against the oldest scoreboard entry.
    always @(negedge clk_gen) begin
        if (rvalid) rv_cnt++;
        if (rst_n && rvalid && rready) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("[TB] FAIL unexpected_word observed=%h required=none", rdata);
            end
            if (exp_q.size() > 0) checkOutput("rdata", rdata, exp_q.pop_front());
        end
    end

    task automatic send_nibble(input logic [3:0] nib, input bit pop_with_edge);
        ddr = nib;
        tick(2);
        lclk = ~lclk;
        if (pop_with_edge) begin
            tick(2);
            rready = 1'b1;
            tick(1);
            rready = 1'b0;
        end else begin
            tick(3);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int nnib,
                                 input bit expect_store, input bit pop_last);
        if (expect_store) exp_q.push_back(word);
        link_valid = 1'b1;
        tick(2);
        for (int i = 0; i < nnib; i++) begin
            send_nibble(word[4*i +: 4], pop_last && (i == nnib - 1));
        end
        link_valid = 1'b0;
        tick(4);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || rvalid); i++) tick(1);
        checkOutput(tag, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tick(3);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_rvalid", rvalid, 1'b0);
        checkOutput("reset_empty", fifo_empty, 1'b1);
        checkOutput("reset_full", fifo_full, 1'b0);
        checkOutput("reset_overflow", overflow, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] single word");
        rready = 1'b1;
        rv_start = rv_cnt;
        applyStimulus(32'hDEADBEEF, 8, 1'b1, 1'b0);
        tick(5);
        checkOutput("single_rvalid_cycles", rv_cnt - rv_start, 32'd1);
        checkOutput("single_drained", exp_q.size(), 32'd0);
        checkOutput("single_overflow", overflow, 1'b0);
        checkOutput("single_frame_err", frame_err, 1'b0);

        $display("[TB] overflow");
        rready = 1'b0;
        for (int w = 1; w <= 3; w++) applyStimulus(32'(w), 8, 1'b1, 1'b0);
        checkOutput("ovf_not_full_at3", fifo_full, 1'b0);
        applyStimulus(32'd4, 8, 1'b1, 1'b0);
        checkOutput("ovf_full_at4", fifo_full, 1'b1);
        checkOutput("ovf_no_overflow_at4", overflow, 1'b0);
        applyStimulus(32'd5, 8, 1'b0, 1'b0);
        checkOutput("ovf_overflow_at5", overflow, 1'b1);
        checkOutput("ovf_still_full", fifo_full, 1'b1);
        rready = 1'b1;
        wait_drain("ovf_drain");
        checkOutput("ovf_empty_after", fifo_empty, 1'b1);
        checkOutput("ovf_sticky", overflow, 1'b1);
        pulse_clear();
        checkOutput("ovf_cleared", overflow, 1'b0);

        $display("[TB] truncated frame");
        applyStimulus(32'h0000_0ABC, 3, 1'b0, 1'b0);
        checkOutput("trunc_frame_err", frame_err, 1'b1);
        checkOutput("trunc_empty", fifo_empty, 1'b1);
        applyStimulus(32'h12345678, 8, 1'b1, 1'b0);
        wait_drain("trunc_next_word");
        checkOutput("trunc_sticky", frame_err, 1'b1);
        pulse_clear();
        checkOutput("trunc_cleared", frame_err, 1'b0);

        $display("[TB] push and pop at full");
        rready = 1'b0;
        for (int w = 0; w < 4; w++) applyStimulus(32'hA000_0000 + 32'(w), 8, 1'b1, 1'b0);
        checkOutput("full_before", fifo_full, 1'b1);
        applyStimulus(32'hB0B0_1234, 8, 1'b1, 1'b1);
        checkOutput("full_pp_overflow", overflow, 1'b0);
        checkOutput("full_pp_still_full", fifo_full, 1'b1);
        rready = 1'b1;
        wait_drain("full_pp_drain");
        for (int w = 0; w < 8; w++) applyStimulus(32'h5EED_0000 + 32'(w * 32'h111), 8, 1'b1, 1'b0);
        wait_drain("wrap_stream");
        checkOutput("wrap_empty", fifo_empty, 1'b1);

        $display("[TB] link events with valid low");
        for (int i = 0; i < 10; i++) begin
            ddr = 4'(i);
            tick(2);
            lclk = ~lclk;
            tick(3);
        end
        tick(4);
        checkOutput("novalid_empty", fifo_empty, 1'b1);
        checkOutput("novalid_overflow", overflow, 1'b0);
        checkOutput("novalid_frame_err", frame_err, 1'b0);

        $display("[TB] reset mid-frame");
        rready = 1'b0;
        applyStimulus(32'h1111_1111, 8, 1'b0, 1'b0);
        applyStimulus(32'h2222_2222, 8, 1'b0, 1'b0);
        applyStimulus(32'h0000_0033, 2, 1'b0, 1'b0);
        checkOutput("mid_pre_rvalid", rvalid, 1'b1);
        checkOutput("mid_pre_frame_err", frame_err, 1'b1);
        link_valid = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) send_nibble(4'(9 + i), 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_rdata", rdata, 32'h0);
        checkOutput("mid_rst_rvalid", rvalid, 1'b0);
        checkOutput("mid_rst_empty", fifo_empty, 1'b1);
        checkOutput("mid_rst_full", fifo_full, 1'b0);
        checkOutput("mid_rst_frame_err", frame_err, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) send_nibble(4'(i + 1), 1'b0);
        link_valid = 1'b0;
        tick(4);
        checkOutput("mid_tail_ignored", fifo_empty, 1'b1);
        checkOutput("mid_tail_no_err", frame_err, 1'b0);
        rready = 1'b1;
        applyStimulus(32'hCAFEF00D, 8, 1'b1, 1'b0);
        wait_drain("mid_next_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
